// File: rtl/monitor_cmd_ctrl_if.sv
// Word-level ports of the debug monitor command engine: UART RX/TX word handshakes and the req/gnt/rvalid memory bus.
interface monitor_cmd_ctrl_if;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [31:0] rx_data_i;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] tx_data_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    // Command engine side
    modport slave (
        input  rx_valid_i, rx_data_i, tx_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output rx_ready_o, tx_valid_o, tx_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // UART / memory side
    modport master (
        output rx_valid_i, rx_data_i, tx_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  rx_ready_o, tx_valid_o, tx_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/monitor_cmd_ctrl.sv
// Debug monitor command engine: decodes UART command words, runs one memory read/write
// with bus timeouts, and returns exactly one response word per command.
module monitor_cmd_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 1024,
    parameter logic [31:0] PING_WORD   = 32'h4D4F4E31
) (
    input  logic              clk_i,
    input  logic              rst_n,
    monitor_cmd_ctrl_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_PING  = 8'h03;

    localparam logic [DATA_W-1:0] RSP_WR_OK  = 32'h000000A5;
    localparam logic [DATA_W-1:0] RSP_GNT_TO = 32'hFFFFFFE0;
    localparam logic [DATA_W-1:0] RSP_RV_TO  = 32'hFFFFFFE1;
    localparam logic [DATA_W-1:0] RSP_BAD_OP = 32'hFFFFFFEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_SEND
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                rx_ready_q, rx_ready_d;
    logic                tx_valid_q, tx_valid_d;
    logic                req_q, req_d;
    logic                rx_hs;
    logic                tx_hs;
    logic                cnt_done;

    assign rx_hs    = bus.rx_valid_i & rx_ready_q;
    assign tx_hs    = tx_valid_q & bus.tx_ready_i;
    assign cnt_done = (cnt_q == CNT_LAST);

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            req_q      <= req_d;
        end
    end

    // Next state; tx_data is only written on transitions into S_SEND
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_data_d = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    case (bus.rx_data_i[7:0])
                        OP_WRITE: begin
                            we_d    = 1'b1;
                            state_d = S_GET_ADDR;
                        end
                        OP_READ: begin
                            we_d    = 1'b0;
                            state_d = S_GET_ADDR;
                        end
                        OP_PING: begin
                            tx_data_d = PING_WORD;
                            state_d   = S_SEND;
                        end
                        default: begin
                            tx_data_d = RSP_BAD_OP;
                            state_d   = S_SEND;
                        end
                    endcase
                end
            end

            S_GET_ADDR: begin
                if (rx_hs) begin
                    addr_d  = {bus.rx_data_i[DATA_W-1:2], 2'b00};
                    cnt_d   = '0;
                    state_d = we_q ? S_GET_DATA : S_BUS_REQ;
                end
            end

            S_GET_DATA: begin
                if (rx_hs) begin
                    wdata_d = bus.rx_data_i;
                    cnt_d   = '0;
                    state_d = S_BUS_REQ;
                end
            end

            // Grant beats a timeout landing in the same cycle
            S_BUS_REQ: begin
                if (bus.mem_gnt_i) begin
                    cnt_d = '0;
                    if (we_q) begin
                        tx_data_d = RSP_WR_OK;
                        state_d   = S_SEND;
                    end else begin
                        state_d = S_BUS_WAIT;
                    end
                end else if (cnt_done) begin
                    cnt_d     = '0;
                    tx_data_d = RSP_GNT_TO;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Read data beats a timeout landing in the same cycle
            S_BUS_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    cnt_d     = '0;
                    tx_data_d = bus.mem_rdata_i;
                    state_d   = S_SEND;
                end else if (cnt_done) begin
                    cnt_d     = '0;
                    tx_data_d = RSP_RV_TO;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SEND: begin
                if (tx_hs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flops follow the state being entered so they line up with it
    always_comb begin
        rx_ready_d = 1'b0;
        tx_valid_d = 1'b0;
        req_d      = 1'b0;
        case (state_d)
            S_IDLE, S_GET_ADDR, S_GET_DATA: rx_ready_d = 1'b1;
            S_BUS_REQ:                      req_d      = 1'b1;
            S_SEND:                         tx_valid_d = 1'b1;
            default: begin
                rx_ready_d = 1'b0;
            end
        endcase
    end

    assign bus.rx_ready_o  = rx_ready_q;
    assign bus.tx_valid_o  = tx_valid_q;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_monitor_cmd_ctrl.sv
// Self-checking bench for monitor_cmd_ctrl: directed scenarios plus random commands
// against a transaction-level response model.
module tb_monitor_cmd_ctrl;
    localparam int          TMO  = 16;
    localparam logic [31:0] PING = 32'h4D4F4E31;

    logic clk = 1'b0;
    logic rst_n;

    monitor_cmd_ctrl_if bus ();

    monitor_cmd_ctrl #(
        .BUS_TIMEOUT (TMO),
        .PING_WORD   (PING)
    ) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response from the command and the bus behaviour offered to it
    function automatic logic [31:0] model_rsp(input logic [7:0] op, input int gnt_d,
                                              input int rv_d, input logic [31:0] rdata);
        if (op == 8'h03) return PING;
        if (op != 8'h01 && op != 8'h02) return 32'hFFFFFFEE;
        if (gnt_d >= TMO) return 32'hFFFFFFE0;
        if (op == 8'h01) return 32'h000000A5;
        return (rv_d <= TMO) ? rdata : 32'hFFFFFFE1;
    endfunction

    task automatic send_word(input logic [31:0] w);
        bit done;
        done = 1'b0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.rx_ready_o === 1'b1) done = 1'b1;
            tick();
        end
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = $urandom;
        chk("rx_accept", 32'(done), 32'd1);
    endtask

    // Grants after gnt_d waiting cycles; rvalid rv_d cycles after the grant
    task automatic bus_serve(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_d, input int rv_d, input logic [31:0] rdata,
                             input int exp_req);
        int k;
        bit granted;
        k = 0;
        granted = 1'b0;
        while (bus.mem_req_o === 1'b1 && k < 200) begin
            k++;
            chk("mem_we", 32'(bus.mem_we_o), 32'(is_wr));
            chk("mem_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
            if (is_wr) chk("mem_wdata", bus.mem_wdata_o, wdata);
            chk("rx_ready_busy", 32'(bus.rx_ready_o), 32'd0);
            bus.mem_gnt_i = (k - 1 == gnt_d);
            granted = bus.mem_gnt_i;
            tick();
            bus.mem_gnt_i = 1'b0;
        end
        chk("req_cycles", 32'(k), 32'(exp_req));
        if (!is_wr && granted) begin
            for (int j = 1; j <= rv_d; j++) begin
                bus.mem_rvalid_i = (j == rv_d);
                bus.mem_rdata_i  = (j == rv_d) ? rdata : $urandom;
                tick();
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = $urandom;
            end
            if (rv_d <= TMO) chk("rvalid_to_tx", 32'(bus.tx_valid_o), 32'd1);
        end
    endtask

    task automatic tx_take(input logic [31:0] exp, input int stall);
        int w;
        w = 0;
        while (bus.tx_valid_o !== 1'b1 && w < 200) begin
            w++;
            tick();
        end
        chk("tx_seen", 32'(bus.tx_valid_o), 32'd1);
        for (int s = 0; s < stall; s++) begin
            chk("tx_data_hold", bus.tx_data_o, exp);
            chk("rx_ready_send", 32'(bus.rx_ready_o), 32'd0);
            tick();
            chk("tx_valid_hold", 32'(bus.tx_valid_o), 32'd1);
        end
        chk("tx_data", bus.tx_data_o, exp);
        bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0;
        chk("tx_valid_drop", 32'(bus.tx_valid_o), 32'd0);
        chk("tx_data_after", bus.tx_data_o, exp);
        chk("rx_ready_idle", 32'(bus.rx_ready_o), 32'd1);
    endtask

    task automatic run_cmd(input logic [31:0] w0, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_d, input int rv_d, input logic [31:0] rdata, input int stall);
        logic [7:0]  op;
        logic [31:0] exp;
        int          exp_req;
        op      = w0[7:0];
        exp     = model_rsp(op, gnt_d, rv_d, rdata);
        exp_req = (gnt_d < TMO) ? gnt_d + 1 : TMO;
        send_word(w0);
        if (op == 8'h01 || op == 8'h02) begin
            send_word(addr);
            if (op == 8'h01) send_word(wdata);
            chk("req_latency", 32'(bus.mem_req_o), 32'd1);
            fork
                bus_serve(op == 8'h01, addr, wdata, gnt_d, rv_d, rdata, exp_req);
                tx_take(exp, stall);
            join
        end else begin
            chk("tx_latency", 32'(bus.tx_valid_o), 32'd1);
            tx_take(exp, stall);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready_o), 32'd0);
        chk({tag, "_tx_valid"}, 32'(bus.tx_valid_o), 32'd0);
        chk({tag, "_tx_data"},  bus.tx_data_o,       32'd0);
        chk({tag, "_mem_req"},  32'(bus.mem_req_o),  32'd0);
        chk({tag, "_mem_we"},   32'(bus.mem_we_o),   32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr_o,      32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata_o,    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0, addr, wdata, rdata;
        int sel, gnt_d, rv_d, stall;

        rst_n            = 1'b0;
        bus.rx_valid_i   = 1'b0;
        bus.rx_data_i    = '0;
        bus.tx_ready_i   = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("rx_ready_after_reset", 32'(bus.rx_ready_o), 32'd1);

        // Directed scenarios
        run_cmd(32'h00000003, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        run_cmd(32'h00000001, 32'h00001003, 32'hDEADBEEF, 2, 0, 32'h0, 0);
        run_cmd(32'h00000002, 32'h00002000, 32'h0, 0, 2, 32'h12345678, 1);
        run_cmd(32'h00000001, 32'h00004444, 32'hCAFEF00D, 100, 0, 32'h0, 2);
        run_cmd(32'h00000002, 32'h00005557, 32'h0, 0, TMO + 2, 32'hBAD0BAD0, 10);
        run_cmd(32'h00000002, 32'h00006000, 32'h0, TMO - 1, TMO, 32'h0BADCAFE, 0);
        run_cmd(32'h000000AB, 32'h0, 32'h0, 0, 0, 32'h0, 20);

        // Reset while waiting for read data
        send_word(32'h00000002);
        send_word(32'h00003000);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk_all_zero("midreset");
        rst_n = 1'b1;
        tick();
        chk("rx_ready_post_reset", 32'(bus.rx_ready_o), 32'd1);
        chk("tx_valid_post_reset", 32'(bus.tx_valid_o), 32'd0);
        run_cmd(32'h00000003, 32'h0, 32'h0, 0, 0, 32'h0, 1);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            sel   = int'($urandom_range(0, 3));
            w0    = $urandom;
            case (sel)
                0:       w0[7:0] = 8'h01;
                1:       w0[7:0] = 8'h02;
                2:       w0[7:0] = 8'h03;
                default: w0[7:0] = 8'($urandom_range(4, 255));
            endcase
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            gnt_d = int'($urandom_range(0, 19));
            rv_d  = int'($urandom_range(1, 19));
            stall = int'($urandom_range(0, 4));
            repeat (int'($urandom_range(0, 2))) tick();
            run_cmd(w0, addr, wdata, gnt_d, rv_d, rdata, stall);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
